// File: rtl/mpu_matrix_reader.sv
// Streams the top-left N x N block of a captured signed 5x5 int8 matrix, row-major, one element per handshake.
// Optional output out_last is enabled with `define MPU_READER_LAST_EN.
module mpu_matrix_reader #(
  parameter int DIM = 5,
  parameter int EW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [0:DIM*DIM*EW-1]   matrix,
  input  logic [7:0]              size,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EW-1:0]           out_data,
  output logic [2:0]              out_row,
  output logic [2:0]              out_col,
  output logic                    done,
`ifdef MPU_READER_LAST_EN
  output logic                    out_last,
`endif
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [0:DIM*DIM*EW-1]   mat_q, mat_d;
  logic [2:0]              n_q, n_d;
  logic [2:0]              i_q, i_d;
  logic [2:0]              j_q, j_d;
  logic                    err_q, err_d;

  logic       size_ok;
  logic [2:0] last_idx;
  logic [4:0] elem_idx;
  logic [7:0] bit_base;

  assign size_ok  = (size != 8'd0) && (size <= 8'(DIM));
  assign last_idx = n_q - 3'd1;
  assign elem_idx = 5'(i_q) * 5'(DIM) + 5'(j_q);
  // Ascending matrix range: bit_base addresses the element's sign bit.
  assign bit_base = 8'(elem_idx) * 8'(EW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            mat_d   = matrix;
            n_d     = size[2:0];
            i_d     = 3'd0;
            j_d     = 3'd0;
            err_d   = 1'b0;
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (j_q == last_idx) begin
            j_d = 3'd0;
            if (i_q == last_idx) begin
              i_d     = 3'd0;
              state_d = DONE;
            end else begin
              i_d = i_q + 3'd1;
            end
          end else begin
            j_d = j_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element fields are forced to zero whenever no element is presented.
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign out_data  = out_valid ? mat_q[bit_base +: EW] : '0;
  assign out_row   = out_valid ? i_q : 3'd0;
  assign out_col   = out_valid ? j_q : 3'd0;

`ifdef MPU_READER_LAST_EN
  assign out_last  = out_valid && (i_q == last_idx) && (j_q == last_idx);
`endif

endmodule

// File: tb/tb_mpu_matrix_reader.sv
// Randomized self-checking bench for mpu_matrix_reader against a row-major queue model.
// Build with +define+MPU_READER_LAST_EN to also check out_last.
module tb_mpu_matrix_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [0:199] matrix;
  logic [7:0]   size;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         done;
  logic         err;
`ifdef MPU_READER_LAST_EN
  logic         out_last;
`endif

  mpu_matrix_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .matrix    (matrix),
    .size      (size),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done),
`ifdef MPU_READER_LAST_EN
    .out_last  (out_last),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
  } elem_t;

  int  tests = 0;
  int  fails = 0;
  byte m[25];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_matrix();
    for (int e = 0; e < 25; e++) matrix[8*e +: 8] = m[e];
  endtask

  // One read-out: start with size n, consume with fixed or random ready, compare to the model.
  task automatic run_stream(input int n, input bit rnd_ready, input bit disturb, input string tag);
    elem_t      q[$];
    elem_t      x;
    bit         legal;
    int         cyc, xfers, dones, valids, last_x, done_c;
    bit         prev_hold;
    logic [7:0] pd;
    logic [2:0] pr, pc;

    legal = (n >= 1) && (n <= 5);
    if (legal)
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          x.d = m[5*i + j];
          x.r = i;
          x.c = j;
          q.push_back(x);
        end

    @(negedge clk);
    size      = 8'(n);
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_first_valid"}, 32'(out_valid), 32'(legal));

    cyc = 0; xfers = 0; dones = 0; valids = 0; last_x = -1; done_c = -1;
    prev_hold = 1'b0; pd = '0; pr = '0; pc = '0;
    while (cyc < 400) begin
      if (prev_hold) begin
        check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_hold_data"}, 32'(out_data), 32'(pd));
        check_eq({tag, "_hold_rc"}, {26'd0, out_row, out_col}, {26'd0, pr, pc});
      end
      if (done) begin
        dones++;
        done_c = cyc;
        check_eq({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_done_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_err"}, 32'(err), 32'(!legal));
        if (disturb) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
        break;
      end
      if (out_valid) begin
        valids++;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        if (q.size() == 0) begin
          check_eq({tag, "_extra_elem"}, 32'(out_valid), 32'd0);
        end else begin
          check_eq({tag, "_data"}, 32'(out_data), 32'(q[0].d));
          check_eq({tag, "_row"}, 32'(out_row), 32'(q[0].r));
          check_eq({tag, "_col"}, 32'(out_col), 32'(q[0].c));
`ifdef MPU_READER_LAST_EN
          check_eq({tag, "_last"}, 32'(out_last), 32'(q.size() == 1));
`endif
        end
      end else begin
        check_eq({tag, "_bubble"}, 32'(out_valid), 32'd1);
      end
      if (disturb && cyc == 3) begin
        for (int e = 0; e < 25; e++) m[e] = byte'($urandom);
        load_matrix();
        size  = 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        xfers++;
        last_x = cyc;
      end
      prev_hold = out_valid && !out_ready;
      pd = out_data; pr = out_row; pc = out_col;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check_eq({tag, "_xfers"}, 32'(xfers), legal ? 32'(n*n) : 32'd0);
    check_eq({tag, "_done_pulses"}, 32'(dones), 32'd1);
    if (!legal) check_eq({tag, "_valid_cycles"}, 32'(valids), 32'd0);
    if (legal && !rnd_ready) begin
      check_eq({tag, "_b2b_cycles"}, 32'(valids), 32'(n*n));
      check_eq({tag, "_done_lat"}, 32'(done_c), 32'(last_x + 1));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; size = '0; matrix = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Full 5x5, ready high
    for (int e = 0; e < 25; e++) m[e] = byte'(e + 1);
    load_matrix();
    run_stream(5, 1'b0, 1'b0, "t2");

    // Reset in the middle of a stream
    @(negedge clk);
    size = 8'd5; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t1_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t1_valid", 32'(out_valid), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_done", 32'(done), 32'd0);
    check_eq("t1_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t1_post_valid", 32'(out_valid), 32'd0);
      check_eq("t1_post_busy", 32'(busy), 32'd0);
      check_eq("t1_post_done", 32'(done), 32'd0);
    end
    out_ready = 1'b0;

    // Submatrix with random ready
    run_stream(3, 1'b1, 1'b0, "t3");

    // Signedness: only element (2,4) = -128
    for (int e = 0; e < 25; e++) m[e] = 8'sd0;
    m[14] = -8'sd128;
    load_matrix();
    run_stream(5, 1'b1, 1'b0, "t4");

    // Illegal sizes, then recovery
    run_stream(0, 1'b1, 1'b0, "t5_size0");
    run_stream(6, 1'b1, 1'b0, "t5_size6");
    run_stream(2, 1'b1, 1'b0, "t5_size2");

    // Capture while busy, start in DONE ignored
    for (int e = 0; e < 25; e++) m[e] = byte'($urandom);
    load_matrix();
    run_stream(4, 1'b1, 1'b1, "t6");

    // Random mixes
    for (int k = 0; k < 8; k++) begin
      for (int e = 0; e < 25; e++) m[e] = byte'($urandom);
      load_matrix();
      run_stream(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
